instr_mem_loadable: RTL

- Parametrised, synchronous successor to the fixed combinational instruction ROM.
- Word-organised instruction RAM with a streaming program-load port (valid/ready handshake, auto-incrementing write pointer) and a registered one-cycle-latency fetch port.
- Out-of-range and misaligned fetches are flagged.
- Sits between the PC/fetch stage and the program loader (UART/boot logic) of the MIPS core.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_array.sv | 28 ++
 rtl/instr_mem_loadable.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// The parity helper is only used when IMEM_PARITY_EN is defined.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } imem_state_e;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-organised synchronous RAM: one write port, one registered read port.
// Contents are deliberately not reset so a program survives a core reset.
module imem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction RAM: streaming program-load port and 1-cycle fetch port.
// Define IMEM_PARITY_EN to store a per-word even-parity bit checked on fetch.
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       IDX_W    = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_ovf,
  output logic              mem_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  output logic              parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  imem_state_e      state_q, state_d;
  logic [IDX_W:0]   ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             word_acc, mem_we;
  logic             fetch_acc, addr_fault;
  logic             valid_q, addr_fault_q, have_resp_q;
  logic             par_bad, resp_fault;
  logic [MEM_W-1:0] wdata, rdata;

  assign load_ready = (state_q == StLoad);
  assign mem_ready  = (state_q == StRun);
  assign load_ovf   = ovf_q;

  // load_start wins over a word offered in the same cycle.
  assign word_acc = load_valid && load_ready && !load_start;
  // Pointer MSB set means it has saturated at DEPTH.
  assign mem_we   = word_acc && !ptr_q[IDX_W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (load_start) begin
          ptr_d = '0;
          ovf_d = 1'b0;
        end else if (word_acc) begin
          if (ptr_q[IDX_W]) begin
            ovf_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
          if (load_last) begin
            state_d = StRun;
            ptr_d   = '0;
          end
        end
      end
      StRun: begin
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fetch_acc  = fetch_req && mem_ready;
  assign addr_fault = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (IDX_W + 2)) != 32'd0);

`ifdef IMEM_PARITY_EN
  assign wdata = {even_parity(64'(load_data)), load_data};
`else
  assign wdata = load_data;
`endif

  imem_array #(
    .WIDTH(MEM_W),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(ptr_q[IDX_W-1:0]),
    .wdata(wdata),
    .re   (fetch_acc),
    .raddr(fetch_addr[IDX_W+1:2]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
      addr_fault_q <= 1'b0;
      have_resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      valid_q <= fetch_acc;
      if (fetch_acc) begin
        addr_fault_q <= addr_fault;
        have_resp_q  <= 1'b1;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_q;

  assign par_bad = have_resp_q && !addr_fault_q &&
                   (even_parity(64'(rdata[DATA_W-1:0])) != rdata[DATA_W]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (valid_q && par_bad) begin
      par_q <= 1'b1;
    end else if (load_start) begin
      par_q <= 1'b0;
    end
  end

  assign parity_err = par_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // The read register only moves on accepted fetches, so the output holds between responses.
  assign resp_fault  = addr_fault_q || par_bad;
  assign fetch_valid = valid_q;
  assign fetch_err   = valid_q && resp_fault;
  assign fetch_instr = (!have_resp_q || resp_fault) ? NOP_WORD : rdata[DATA_W-1:0];

endmodule
